lv_reg_arb: RTL and testbench

- Arbitrates single-port access to the LV configuration/status register bank among three requesters: SPI slave, one-wire (OW) comm, and CRC watchdog scanner.
- Sits in lv_core, between those requesters and the register bank.
- Enable and write-permission gates come from the LV control FSM outputs (spi/ow_comm/crc_wdg/cfg ctrl).
- Fixed priority SPI > OW > CRC, with a starvation override for CRC.

---
 rtl/lv_pkg.sv | 26 ++
 rtl/lv_reg_arb_sel.sv | 37 +++
 rtl/lv_reg_arb.sv | 202 ++++++++++++++++++++
 tb/tb_lv_reg_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lv_pkg.sv
// ---------------------------------------------------------------------------
// lv_pkg
// Shared definitions for the LV register bank access path.
//   - default address/data widths and the number of implemented registers
//   - requester identifiers used by the register arbiter
//   - state encoding of the register arbiter FSM
// ---------------------------------------------------------------------------
package lv_pkg;

  localparam int LV_ADDR_W  = 7;
  localparam int LV_DATA_W  = 8;
  localparam int LV_REG_NUM = 96;

  typedef enum logic [1:0] {
    REQ_SPI = 2'd0,
    REQ_OW  = 2'd1,
    REQ_CRC = 2'd2
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/lv_reg_arb_sel.sv
// ---------------------------------------------------------------------------
// lv_reg_arb_sel
// Combinational winner selection for the LV register arbiter.
// Fixed priority SPI > OW > CRC, except that a starved CRC requester beats
// everyone.
// Ports:
//   spi_vld, ow_vld, crc_vld  in   eligible (gated) requests
//   starve                    in   CRC starvation counter has saturated
//   grant_vld                 out  some request is eligible
//   grant_id                  out  winning requester (SPI when none)
// ---------------------------------------------------------------------------
module lv_reg_arb_sel
  import lv_pkg::*;
(
  input  logic    spi_vld,
  input  logic    ow_vld,
  input  logic    crc_vld,
  input  logic    starve,
  output logic    grant_vld,
  output req_id_e grant_id
);

  always_comb begin
    grant_vld = spi_vld | ow_vld | crc_vld;
    grant_id  = REQ_SPI;
    if (crc_vld && starve) begin
      grant_id = REQ_CRC;
    end else if (spi_vld) begin
      grant_id = REQ_SPI;
    end else if (ow_vld) begin
      grant_id = REQ_OW;
    end else if (crc_vld) begin
      grant_id = REQ_CRC;
    end
  end

endmodule

// File: rtl/lv_reg_arb.sv
// ---------------------------------------------------------------------------
// lv_reg_arb
// Single-port access arbiter for the LV configuration/status register bank.
// Requesters: SPI slave, one-wire comm, CRC watchdog scanner (read-only).
// Each access takes three cycles: IDLE (grant) -> ACC (bank strobe) ->
// RESP (ack, read data capture).
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_sft_rst               synchronous abort/soft reset
//   i_*_ctrl, i_cfg_ctrl    requester enables and write permission
//   i_*_req/wr/addr/wdata   requester access interface
//   o_*_ack/rdata/err       requester responses
//   o_reg_*, i_reg_rdata    register bank interface
//   o_acc_err               pulse per rejected access
// ---------------------------------------------------------------------------
module lv_reg_arb
  import lv_pkg::*;
#(
  parameter int ADDR_W   = LV_ADDR_W,
  parameter int DATA_W   = LV_DATA_W,
  parameter int REG_NUM  = LV_REG_NUM,
  parameter int WAIT_MAX = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sft_rst,
  input  logic              i_spi_ctrl,
  input  logic              i_ow_comm_ctrl,
  input  logic              i_crc_wdg_ctrl,
  input  logic              i_cfg_ctrl,
  input  logic              i_spi_req,
  input  logic              i_ow_req,
  input  logic              i_crc_req,
  input  logic              i_spi_wr,
  input  logic              i_ow_wr,
  input  logic [ADDR_W-1:0] i_spi_addr,
  input  logic [ADDR_W-1:0] i_ow_addr,
  input  logic [ADDR_W-1:0] i_crc_addr,
  input  logic [DATA_W-1:0] i_spi_wdata,
  input  logic [DATA_W-1:0] i_ow_wdata,
  output logic              o_spi_ack,
  output logic              o_ow_ack,
  output logic              o_crc_ack,
  output logic [DATA_W-1:0] o_spi_rdata,
  output logic [DATA_W-1:0] o_ow_rdata,
  output logic [DATA_W-1:0] o_crc_rdata,
  output logic              o_spi_err,
  output logic              o_ow_err,
  output logic              o_reg_en,
  output logic              o_reg_wr,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [DATA_W-1:0] o_reg_wdata,
  input  logic [DATA_W-1:0] i_reg_rdata,
  output logic              o_acc_err
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0]   WAIT_LIM = WAIT_MAX[CW-1:0];
  localparam logic [ADDR_W:0] REG_LIM  = REG_NUM[ADDR_W:0];

  arb_state_e        state;
  req_id_e           cur_id;
  logic              legal_q;
  logic [CW-1:0]     starve_cnt;
  logic [DATA_W-1:0] spi_rdata_q;
  logic [DATA_W-1:0] ow_rdata_q;
  logic [DATA_W-1:0] crc_rdata_q;

  logic              spi_elig;
  logic              ow_elig;
  logic              crc_elig;
  logic              grant_vld;
  req_id_e           grant_id;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              legal_now;
  logic              resp_go;
  logic              rd_take;
  logic              crc_served;

  assign spi_elig = i_spi_ctrl & i_spi_req;
  assign ow_elig  = i_ow_comm_ctrl & i_ow_req;
  assign crc_elig = i_crc_wdg_ctrl & i_crc_req;

  lv_reg_arb_sel u_sel (
    .spi_vld   (spi_elig),
    .ow_vld    (ow_elig),
    .crc_vld   (crc_elig),
    .starve    (starve_cnt == WAIT_LIM),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  // Fields of the winning request, latched on grant.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = i_crc_addr;
    sel_wdata = '0;
    case (grant_id)
      REQ_SPI: begin
        sel_wr    = i_spi_wr;
        sel_addr  = i_spi_addr;
        sel_wdata = i_spi_wdata;
      end
      REQ_OW: begin
        sel_wr    = i_ow_wr;
        sel_addr  = i_ow_addr;
        sel_wdata = i_ow_wdata;
      end
      default: ;
    endcase
  end

  // Write permission is judged live in ACC, so the bank strobe and the
  // abort input act within the same cycle instead of being registered.
  assign legal_now = ~(o_reg_wr & ~i_cfg_ctrl) & ({1'b0, o_reg_addr} < REG_LIM);
  assign o_reg_en  = (state == ACC) & ~i_sft_rst & legal_now;

  assign resp_go   = (state == RESP) & ~i_sft_rst;
  assign rd_take   = resp_go & legal_q & ~o_reg_wr;
  assign o_spi_ack = resp_go & (cur_id == REQ_SPI);
  assign o_ow_ack  = resp_go & (cur_id == REQ_OW);
  assign o_crc_ack = resp_go & (cur_id == REQ_CRC);
  assign o_spi_err = o_spi_ack & ~legal_q;
  assign o_ow_err  = o_ow_ack & ~legal_q;
  assign o_acc_err = resp_go & ~legal_q;

  // Bank data is only valid during RESP, so it is passed straight through
  // alongside the ack and captured for the hold period afterwards.
  assign o_spi_rdata = (rd_take && cur_id == REQ_SPI) ? i_reg_rdata : spi_rdata_q;
  assign o_ow_rdata  = (rd_take && cur_id == REQ_OW)  ? i_reg_rdata : ow_rdata_q;
  assign o_crc_rdata = (rd_take && cur_id == REQ_CRC) ? i_reg_rdata : crc_rdata_q;

  // Arbiter FSM with latched access fields and read data hold registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cur_id      <= REQ_SPI;
      legal_q     <= 1'b0;
      o_reg_wr    <= 1'b0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
      spi_rdata_q <= '0;
      ow_rdata_q  <= '0;
      crc_rdata_q <= '0;
    end else if (i_sft_rst) begin
      state       <= IDLE;
      cur_id      <= REQ_SPI;
      legal_q     <= 1'b0;
      o_reg_wr    <= 1'b0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
      spi_rdata_q <= '0;
      ow_rdata_q  <= '0;
      crc_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            cur_id      <= grant_id;
            o_reg_wr    <= sel_wr;
            o_reg_addr  <= sel_addr;
            o_reg_wdata <= sel_wdata;
            state       <= ACC;
          end
        end
        ACC: begin
          legal_q <= legal_now;
          state   <= RESP;
        end
        RESP: begin
          if (rd_take) begin
            case (cur_id)
              REQ_SPI: spi_rdata_q <= i_reg_rdata;
              REQ_OW:  ow_rdata_q  <= i_reg_rdata;
              default: crc_rdata_q <= i_reg_rdata;
            endcase
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // CRC is considered served from its grant until its own access ends,
  // so the counter only measures time lost to other requesters.
  assign crc_served = ((state == IDLE) && grant_vld && (grant_id == REQ_CRC)) ||
                      ((state != IDLE) && (cur_id == REQ_CRC));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (i_sft_rst || !crc_elig || crc_served) begin
      starve_cnt <= '0;
    end else if (starve_cnt != WAIT_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lv_reg_arb.sv
// ---------------------------------------------------------------------------
// tb_lv_reg_arb
// Directed self-checking bench for lv_reg_arb. Inputs change and outputs
// are sampled on the falling clock edge; cycle c of a scenario is the
// c-th falling edge after the requests are raised in an IDLE cycle.
// ---------------------------------------------------------------------------
module tb_lv_reg_arb;
  import lv_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       sft_rst;
  logic       spi_ctrl, ow_ctrl, crc_ctrl, cfg_ctrl;
  logic       spi_req, ow_req, crc_req;
  logic       spi_wr, ow_wr;
  logic [6:0] spi_addr, ow_addr, crc_addr;
  logic [7:0] spi_wdata, ow_wdata;
  logic       spi_ack, ow_ack, crc_ack;
  logic [7:0] spi_rdata, ow_rdata, crc_rdata;
  logic       spi_err, ow_err;
  logic       reg_en, reg_wr;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       acc_err;

  int checks   = 0;
  int failures = 0;

  lv_reg_arb u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sft_rst      (sft_rst),
    .i_spi_ctrl     (spi_ctrl),
    .i_ow_comm_ctrl (ow_ctrl),
    .i_crc_wdg_ctrl (crc_ctrl),
    .i_cfg_ctrl     (cfg_ctrl),
    .i_spi_req      (spi_req),
    .i_ow_req       (ow_req),
    .i_crc_req      (crc_req),
    .i_spi_wr       (spi_wr),
    .i_ow_wr        (ow_wr),
    .i_spi_addr     (spi_addr),
    .i_ow_addr      (ow_addr),
    .i_crc_addr     (crc_addr),
    .i_spi_wdata    (spi_wdata),
    .i_ow_wdata     (ow_wdata),
    .o_spi_ack      (spi_ack),
    .o_ow_ack       (ow_ack),
    .o_crc_ack      (crc_ack),
    .o_spi_rdata    (spi_rdata),
    .o_ow_rdata     (ow_rdata),
    .o_crc_rdata    (crc_rdata),
    .o_spi_err      (spi_err),
    .o_ow_err       (ow_err),
    .o_reg_en       (reg_en),
    .o_reg_wr       (reg_wr),
    .o_reg_addr     (reg_addr),
    .o_reg_wdata    (reg_wdata),
    .i_reg_rdata    (reg_rdata),
    .o_acc_err      (acc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sft_rst = 1'b0;
    spi_ctrl = 1'b1; ow_ctrl = 1'b1; crc_ctrl = 1'b1; cfg_ctrl = 1'b1;
    spi_req = 1'b0; ow_req = 1'b0; crc_req = 1'b0;
    spi_wr = 1'b0; ow_wr = 1'b0;
    spi_addr = '0; ow_addr = '0; crc_addr = '0;
    spi_wdata = '0; ow_wdata = '0; reg_rdata = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({reg_en, reg_wr, spi_ack, ow_ack, crc_ack, spi_err, ow_err, acc_err} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_ctrl actual=%b expected=00000000",
               {reg_en, reg_wr, spi_ack, ow_ack, crc_ack, spi_err, ow_err, acc_err});
    end
    checks++;
    if ({spi_rdata, ow_rdata, crc_rdata} !== 24'h0) begin
      failures++;
      $display("[TB] FAIL reset_rdata actual=%h expected=000000", {spi_rdata, ow_rdata, crc_rdata});
    end
    checks++;
    if ({reg_addr, reg_wdata} !== 15'h0) begin
      failures++;
      $display("[TB] FAIL reset_bank actual=%h expected=0000", {reg_addr, reg_wdata});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_spi_write;
    @(negedge clk);
    spi_req = 1'b1; spi_wr = 1'b1; spi_addr = 7'h10; spi_wdata = 8'hA5;
    step();
    checks++;
    if ({reg_en, reg_wr, reg_addr, reg_wdata, spi_ack} !== {1'b1, 1'b1, 7'h10, 8'hA5, 1'b0}) begin
      failures++;
      $display("[TB] FAIL spi_wr_strobe actual=%b/%b/%h/%h/%b expected=1/1/10/a5/0",
               reg_en, reg_wr, reg_addr, reg_wdata, spi_ack);
    end
    step();
    checks++;
    if ({spi_ack, spi_err, acc_err, reg_en} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL spi_wr_ack actual=%b expected=1000", {spi_ack, spi_err, acc_err, reg_en});
    end
    spi_req = 1'b0;
  endtask

  task automatic test_all_three;
    logic [2:0] exp;
    @(negedge clk);
    reg_rdata = 8'h99;
    spi_req = 1'b1; spi_wr = 1'b0; spi_addr = 7'h01;
    ow_req = 1'b1; ow_wr = 1'b0; ow_addr = 7'h02;
    crc_req = 1'b1; crc_addr = 7'h03;
    for (int c = 1; c <= 9; c++) begin
      step();
      exp = (c == 2) ? 3'b100 : (c == 5) ? 3'b010 : (c == 8) ? 3'b001 : 3'b000;
      checks++;
      if ({spi_ack, ow_ack, crc_ack} !== exp) begin
        failures++;
        $display("[TB] FAIL prio_ack_c%0d actual=%b expected=%b", c, {spi_ack, ow_ack, crc_ack}, exp);
      end
      if (exp[2]) spi_req = 1'b0;
      if (exp[1]) ow_req = 1'b0;
      if (exp[0]) begin
        crc_req = 1'b0;
        checks++;
        if ({spi_rdata, ow_rdata, crc_rdata} !== 24'h999999) begin
          failures++;
          $display("[TB] FAIL prio_rdata actual=%h expected=999999", {spi_rdata, ow_rdata, crc_rdata});
        end
      end
    end
  endtask

  task automatic test_starvation;
    int spi_before;
    int crc_cycle;
    int next_spi;
    spi_before = 0; crc_cycle = -1; next_spi = -1;
    @(negedge clk);
    spi_req = 1'b1; spi_wr = 1'b1; spi_addr = 7'h11; spi_wdata = 8'h5A;
    crc_req = 1'b1; crc_addr = 7'h04;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (spi_ack) begin
        if (crc_cycle < 0) spi_before++;
        else if (next_spi < 0) next_spi = c;
      end
      if (crc_ack && crc_cycle < 0) begin
        crc_cycle = c;
        crc_req = 1'b0;
      end
    end
    spi_req = 1'b0;
    checks++;
    if (crc_cycle != 20) begin
      failures++;
      $display("[TB] FAIL starve_crc_cycle actual=%0d expected=20", crc_cycle);
    end
    checks++;
    if (spi_before != 6) begin
      failures++;
      $display("[TB] FAIL starve_spi_count actual=%0d expected=6", spi_before);
    end
    checks++;
    if (next_spi != 23) begin
      failures++;
      $display("[TB] FAIL starve_next_spi actual=%0d expected=23", next_spi);
    end
  endtask

  task automatic test_illegal;
    reg_rdata = 8'h77;
    // OW write while writes are locked
    @(negedge clk);
    cfg_ctrl = 1'b0;
    ow_req = 1'b1; ow_wr = 1'b1; ow_addr = 7'h20; ow_wdata = 8'h12;
    step();
    checks++;
    if (reg_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ow_lock_en actual=%b expected=0", reg_en);
    end
    step();
    checks++;
    if ({ow_ack, ow_err, acc_err, ow_rdata} !== {3'b111, 8'h99}) begin
      failures++;
      $display("[TB] FAIL ow_lock_ack actual=%b/%h expected=111/99", {ow_ack, ow_err, acc_err}, ow_rdata);
    end
    ow_req = 1'b0; cfg_ctrl = 1'b1;
    // SPI read out of range
    @(negedge clk);
    spi_req = 1'b1; spi_wr = 1'b0; spi_addr = 7'h60;
    step();
    checks++;
    if (reg_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL spi_oor_en actual=%b expected=0", reg_en);
    end
    step();
    checks++;
    if ({spi_ack, spi_err, acc_err, spi_rdata} !== {3'b111, 8'h99}) begin
      failures++;
      $display("[TB] FAIL spi_oor_ack actual=%b/%h expected=111/99", {spi_ack, spi_err, acc_err}, spi_rdata);
    end
    spi_req = 1'b0;
    // CRC read out of range
    @(negedge clk);
    crc_req = 1'b1; crc_addr = 7'h70;
    step();
    step();
    checks++;
    if ({crc_ack, acc_err, crc_rdata} !== {2'b11, 8'h99}) begin
      failures++;
      $display("[TB] FAIL crc_oor_ack actual=%b/%h expected=11/99", {crc_ack, acc_err}, crc_rdata);
    end
    crc_req = 1'b0;
  endtask

  task automatic test_crc_read;
    int seen;
    reg_rdata = 8'h3C;
    @(negedge clk);
    crc_req = 1'b1; crc_addr = 7'h05;
    step();
    checks++;
    if ({reg_en, reg_wr, reg_addr} !== {2'b10, 7'h05}) begin
      failures++;
      $display("[TB] FAIL crc_rd_strobe actual=%b/%b/%h expected=1/0/05", reg_en, reg_wr, reg_addr);
    end
    step();
    checks++;
    if ({crc_ack, acc_err, crc_rdata} !== {2'b10, 8'h3C}) begin
      failures++;
      $display("[TB] FAIL crc_rd_ack actual=%b/%h expected=10/3c", {crc_ack, acc_err}, crc_rdata);
    end
    crc_req = 1'b0;
    // Same request with the CRC gate closed
    @(negedge clk);
    crc_ctrl = 1'b0; crc_req = 1'b1;
    seen = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (crc_ack || reg_en) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("[TB] FAIL crc_gated actual=%0d expected=0", seen);
    end
    crc_req = 1'b0; crc_ctrl = 1'b1;
  endtask

  task automatic test_gate_drop;
    reg_rdata = 8'hC3;
    @(negedge clk);
    spi_req = 1'b1; spi_wr = 1'b0; spi_addr = 7'h07;
    step();
    spi_ctrl = 1'b0;
    step();
    checks++;
    if ({spi_ack, spi_err, spi_rdata} !== {2'b10, 8'hC3}) begin
      failures++;
      $display("[TB] FAIL gate_drop_ack actual=%b/%h expected=10/c3", {spi_ack, spi_err}, spi_rdata);
    end
    spi_req = 1'b0; spi_ctrl = 1'b1;
  endtask

  task automatic test_sft_rst;
    @(negedge clk);
    spi_req = 1'b1; spi_wr = 1'b1; spi_addr = 7'h12; spi_wdata = 8'h34;
    step();
    sft_rst = 1'b1;
    #1;
    checks++;
    if (reg_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sft_rst_en actual=%b expected=0", reg_en);
    end
    step();
    sft_rst = 1'b0;
    checks++;
    if ({spi_ack, spi_rdata} !== {1'b0, 8'h00}) begin
      failures++;
      $display("[TB] FAIL sft_rst_noack actual=%b/%h expected=0/00", spi_ack, spi_rdata);
    end
    step();
    checks++;
    if ({reg_en, reg_addr} !== {1'b1, 7'h12}) begin
      failures++;
      $display("[TB] FAIL sft_rst_regrant actual=%b/%h expected=1/12", reg_en, reg_addr);
    end
    step();
    checks++;
    if (spi_ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sft_rst_ack actual=%b expected=1", spi_ack);
    end
    spi_req = 1'b0;
  endtask

  task automatic test_async_reset;
    reg_rdata = 8'h66;
    @(negedge clk);
    spi_req = 1'b1; spi_wr = 1'b0; spi_addr = 7'h08;
    step();
    step();
    checks++;
    if ({spi_ack, spi_rdata} !== {1'b1, 8'h66}) begin
      failures++;
      $display("[TB] FAIL arst_pre_ack actual=%b/%h expected=1/66", spi_ack, spi_rdata);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({spi_ack, spi_err, acc_err, reg_en, reg_wr, reg_addr, reg_wdata, spi_rdata, ow_rdata, crc_rdata} !== '0) begin
      failures++;
      $display("[TB] FAIL arst_clear actual=%b/%h/%h/%h/%h/%h expected=0",
               {spi_ack, spi_err, acc_err, reg_en, reg_wr}, reg_addr, reg_wdata, spi_rdata, ow_rdata, crc_rdata);
    end
    spi_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] lv_reg_arb directed tests");
    test_reset();
    test_spi_write();
    test_all_three();
    test_starvation();
    test_illegal();
    test_crc_read();
    test_gate_drop();
    test_sft_rst();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
